// File: rtl/conv33_pkg.sv
// conv33_pkg: shared types and constants for the 3x3 convolution MAC stage.
//   state_t       : MAC FSM states (ACC = taking taps, HOLD = result presented)
//   KERNEL_SIZE   : taps per output window (3x3)
//   *_WIDTH_DEF   : default operand / accumulator widths
//   sext_product  : signed pixel*weight product sign-extended to OUT_WIDTH_DEF
package conv33_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int OUT_WIDTH_DEF  = 32;
  localparam int KERNEL_SIZE    = 9;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [OUT_WIDTH_DEF-1:0] sext_product(
    input logic signed [DATA_WIDTH_DEF-1:0] pix,
    input logic signed [DATA_WIDTH_DEF-1:0] wgt
  );
    logic signed [2*DATA_WIDTH_DEF-1:0] p;
    p = pix * wgt;
    return {{(OUT_WIDTH_DEF-2*DATA_WIDTH_DEF){p[2*DATA_WIDTH_DEF-1]}}, p};
  endfunction

endpackage

// File: rtl/conv33_mul.sv
// conv33_mul: combinational signed DATA_WIDTH x DATA_WIDTH multiplier.
// Kept as its own block so a DSP-mapped or pipelined multiplier can replace it.
//   i_a, i_b : signed operands
//   o_p      : full-precision signed product (2*DATA_WIDTH bits)
module conv33_mul #(
  parameter int DATA_WIDTH = conv33_pkg::DATA_WIDTH_DEF
) (
  input  logic signed [DATA_WIDTH-1:0]   i_a,
  input  logic signed [DATA_WIDTH-1:0]   i_b,
  output logic signed [2*DATA_WIDTH-1:0] o_p
);

  assign o_p = i_a * i_b;

endmodule

// File: rtl/conv33_mac.sv
// conv33_mac: 3x3 convolution multiply-accumulate stage.
// Takes KERNEL_SIZE signed (pixel, weight) pairs per window, adds the bias
// sampled with tap 0 and presents one wrapped OUT_WIDTH sum downstream.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where the
// producer's valid and the consumer's ready are both high. ready never depends
// on valid in the same cycle; a presented result stays stable until taken.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : stage enable; low blocks tap acceptance (output side unaffected)
//   valid_in    : tap pair valid          ready_out : stage can accept a tap
//   pix_in      : signed pixel            wgt_in    : signed weight
//   bias_in     : signed bias, used only with tap 0 of a window
//   valid_out   : result valid            ready_in  : downstream ready
//   data_out    : signed window sum
//   done        : one-cycle pulse the cycle after a result is accepted
//   dbg_state   : current FSM state, for observation only
module conv33_mac #(
  parameter int DATA_WIDTH  = conv33_pkg::DATA_WIDTH_DEF,
  parameter int OUT_WIDTH   = conv33_pkg::OUT_WIDTH_DEF,
  parameter int KERNEL_SIZE = conv33_pkg::KERNEL_SIZE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         valid_in,
  output logic                         ready_out,
  input  logic signed [DATA_WIDTH-1:0] pix_in,
  input  logic signed [DATA_WIDTH-1:0] wgt_in,
  input  logic signed [OUT_WIDTH-1:0]  bias_in,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic signed [OUT_WIDTH-1:0]  data_out,
  output logic                         done,
  output conv33_pkg::state_t           dbg_state
);

  import conv33_pkg::*;

  localparam int CNT_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(KERNEL_SIZE - 1);

  state_t                   r_state,   w_state_nxt;
  logic [CNT_W-1:0]         r_tap_cnt, w_tap_cnt_nxt;
  logic [OUT_WIDTH-1:0]     r_acc,     w_acc_nxt;
  logic [OUT_WIDTH-1:0]     r_data,    w_data_nxt;
  logic                     r_valid,   w_valid_nxt;
  logic                     r_done,    w_done_nxt;

  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic [OUT_WIDTH-1:0]           w_prod_ext;
  logic [OUT_WIDTH-1:0]           w_sum;
  logic                           w_accept;

  conv33_mul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .i_a (pix_in),
    .i_b (wgt_in),
    .o_p (w_prod)
  );

  assign w_prod_ext = {{(OUT_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};

  // Tap 0 starts from the fresh bias; any bias left on the bus from an
  // earlier window is never folded into later taps.
  assign w_sum = (r_tap_cnt == '0) ? ($unsigned(bias_in) + w_prod_ext)
                                   : (r_acc + w_prod_ext);

  assign ready_out = start && (r_state == ACC);
  assign w_accept  = valid_in && ready_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ACC;
      r_tap_cnt <= '0;
      r_acc     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tap_cnt <= w_tap_cnt_nxt;
      r_acc     <= w_acc_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tap_cnt_nxt = r_tap_cnt;
    w_acc_nxt     = r_acc;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_done_nxt    = 1'b0;

    case (r_state)
      ACC: begin
        if (w_accept) begin
          w_acc_nxt = w_sum;
          if (r_tap_cnt == LAST_TAP) begin
            w_data_nxt    = w_sum;
            w_valid_nxt   = 1'b1;
            w_tap_cnt_nxt = '0;
            w_state_nxt   = HOLD;
          end else begin
            w_tap_cnt_nxt = r_tap_cnt + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        // start is deliberately ignored here: it only gates the input side.
        if (r_valid && ready_in) begin
          w_valid_nxt = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = ACC;
        end
      end
      default: begin
        w_state_nxt = ACC;
      end
    endcase
  end

  assign valid_out = r_valid;
  assign data_out  = $signed(r_data);
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule
